mem_port_arbiter: RTL and testbench

//  Shares the single memory bus port between if_stage (instruction fetch) and m_stage (load/store).

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_starve_ctr.sv | 34 +++
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the memory-port arbiter: state encoding,
// starvation counter width and its saturating increment.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_BUSY_IF  = 2'd1,
    ARB_BUSY_MEM = 2'd2
  } arb_state_e;

  // Wide enough for the largest allowed starvation limit (15).
  localparam int CNT_W = 4;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic [CNT_W-1:0] limit);
    logic [CNT_W-1:0] result;
    if (value >= limit) begin
      result = limit;
    end else begin
      result = value + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return result;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_starve_ctr.sv
// Saturating counter of consecutive MEM wins while a fetch is waiting;
// sat tells the arbiter that the fetch side must win the next contest.
module mem_port_arbiter_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt_r;

  // Count register: clear has priority over increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc) begin
      cnt_r <= sat_inc(cnt_r, LIMIT_V);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign sat = (cnt_r == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory bus port between instruction fetch and load/store.
// MEM has fixed priority, except when the starvation guard hands the win to IF.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                mem_req,
  input  logic                mem_we,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W/8-1:0] mem_wmask,
  output logic                mem_gnt,
  output logic                mem_rvalid,
  output logic [DATA_W-1:0]   mem_rdata,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  output logic [DATA_W/8-1:0] bus_wmask,
  input  logic                bus_ack,
  input  logic [DATA_W-1:0]   bus_rdata
);

  localparam int WM_W = DATA_W / 8;

  arb_state_e state_r;
  arb_state_e state_nxt_s;
  logic       if_win_s;
  logic       mem_win_s;
  logic       starve_sat_s;
  logic       if_done_s;
  logic       mem_done_s;

  mem_port_arbiter_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_ctr (
    .clk (clk),
    .rst (rst),
    .inc (mem_gnt & if_req),
    .clr (if_gnt),
    .sat (starve_sat_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and winner selection; grants only ever come out of IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if_win_s    = 1'b0;
    mem_win_s   = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (mem_req && !(if_req && starve_sat_s)) begin
          mem_win_s   = 1'b1;
          state_nxt_s = ARB_BUSY_MEM;
        end else if (if_req) begin
          if_win_s    = 1'b1;
          state_nxt_s = ARB_BUSY_IF;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_MEM: begin
        if (bus_ack) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // A grant during reset would be dropped, so it is never shown.
  assign if_gnt     = if_win_s & ~rst;
  assign mem_gnt    = mem_win_s & ~rst;
  assign if_done_s  = (state_r == ARB_BUSY_IF) & bus_ack;
  assign mem_done_s = (state_r == ARB_BUSY_MEM) & bus_ack;

  // Bus side: latch the winner's fields at the grant edge and hold them until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= {ADDR_W{1'b0}};
      bus_wdata <= {DATA_W{1'b0}};
      bus_wmask <= {WM_W{1'b0}};
    end else if (mem_gnt) begin
      bus_req   <= 1'b1;
      bus_we    <= mem_we;
      bus_addr  <= mem_addr;
      bus_wdata <= mem_wdata;
      bus_wmask <= mem_wmask;
    end else if (if_gnt) begin
      bus_req   <= 1'b1;
      bus_we    <= 1'b0;
      bus_addr  <= if_addr;
      bus_wdata <= {DATA_W{1'b0}};
      bus_wmask <= {WM_W{1'b0}};
    end else if (if_done_s || mem_done_s) begin
      bus_req   <= 1'b0;
    end else begin
      bus_req   <= bus_req;
    end
  end

  // Response side: one-cycle rvalid with data, zero whenever nothing completed.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rvalid  <= 1'b0;
      if_rdata   <= {DATA_W{1'b0}};
      mem_rvalid <= 1'b0;
      mem_rdata  <= {DATA_W{1'b0}};
    end else begin
      if_rvalid  <= if_done_s;
      if_rdata   <= if_done_s ? bus_rdata : {DATA_W{1'b0}};
      mem_rvalid <= mem_done_s;
      mem_rdata  <= (mem_done_s && !bus_we) ? bus_rdata : {DATA_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter, checked every cycle
// against a transaction-level model of the arbiter's rules.
module tb_mem_port_arbiter;

  localparam int LIM = 4;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [63:0] if_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [63:0] mem_rdata;
  logic        bus_req;
  logic        bus_we;
  logic [63:0] bus_addr;
  logic [63:0] bus_wdata;
  logic [7:0]  bus_wmask;
  logic        bus_ack;
  logic [63:0] bus_rdata;

  mem_port_arbiter #(
    .ADDR_W       (64),
    .DATA_W       (64),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wmask  (mem_wmask),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_wmask  (bus_wmask),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: one outstanding transaction, a starvation tally, pending responses.
  bit          m_busy = 1'b0;
  bit          m_is_mem = 1'b0;
  int          m_starve = 0;
  logic        m_we = 1'b0;
  logic [63:0] m_addr = 64'd0;
  logic [63:0] m_wdata = 64'd0;
  logic [7:0]  m_wmask = 8'd0;
  logic        m_if_rv = 1'b0;
  logic [63:0] m_if_rd = 64'd0;
  logic        m_mem_rv = 1'b0;
  logic [63:0] m_mem_rd = 64'd0;
  bit          g_if = 1'b0;
  bit          g_mem = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check the current cycle against the model, then advance one clock edge.
  task automatic cycle();
    g_if  = 1'b0;
    g_mem = 1'b0;
    if (!rst && !m_busy) begin
      if (mem_req && !(if_req && m_starve == LIM)) g_mem = 1'b1;
      else if (if_req) g_if = 1'b1;
    end
    chk("if_gnt",     64'(if_gnt),     64'(g_if));
    chk("mem_gnt",    64'(mem_gnt),    64'(g_mem));
    chk("bus_req",    64'(bus_req),    64'(m_busy));
    chk("bus_we",     64'(bus_we),     64'(m_we));
    chk("bus_addr",   bus_addr,        m_addr);
    chk("bus_wdata",  bus_wdata,       m_wdata);
    chk("bus_wmask",  64'(bus_wmask),  64'(m_wmask));
    chk("if_rvalid",  64'(if_rvalid),  64'(m_if_rv));
    chk("if_rdata",   if_rdata,        m_if_rd);
    chk("mem_rvalid", 64'(mem_rvalid), 64'(m_mem_rv));
    chk("mem_rdata",  mem_rdata,       m_mem_rd);
    @(posedge clk);
    if (rst) begin
      m_busy = 1'b0; m_starve = 0; m_we = 1'b0;
      m_addr = 64'd0; m_wdata = 64'd0; m_wmask = 8'd0;
      m_if_rv = 1'b0; m_if_rd = 64'd0; m_mem_rv = 1'b0; m_mem_rd = 64'd0;
    end else begin
      m_if_rv  = m_busy && !m_is_mem && bus_ack;
      m_if_rd  = m_if_rv ? bus_rdata : 64'd0;
      m_mem_rv = m_busy && m_is_mem && bus_ack;
      m_mem_rd = (m_mem_rv && !m_we) ? bus_rdata : 64'd0;
      if (m_busy) begin
        if (bus_ack) m_busy = 1'b0;
      end else if (g_mem) begin
        m_busy = 1'b1; m_is_mem = 1'b1; m_we = mem_we;
        m_addr = mem_addr; m_wdata = mem_wdata; m_wmask = mem_wmask;
        if (if_req) m_starve = (m_starve < LIM) ? m_starve + 1 : LIM;
      end else if (g_if) begin
        m_busy = 1'b1; m_is_mem = 1'b0; m_we = 1'b0;
        m_addr = if_addr; m_wdata = 64'd0; m_wmask = 8'd0;
        m_starve = 0;
      end
    end
    #1;
  endtask

  task automatic set_in(input logic ir, input logic [63:0] ia, input logic mr, input logic we,
                        input logic [63:0] ma, input logic [63:0] wd, input logic [7:0] wm,
                        input logic ack, input logic [63:0] rd);
    if_req = ir; if_addr = ia; mem_req = mr; mem_we = we; mem_addr = ma;
    mem_wdata = wd; mem_wmask = wm; bus_ack = ack; bus_rdata = rd;
    #1;
  endtask

  initial begin
    bit seq_if [$];
    rst = 1'b1;
    if_req = 1'b0; if_addr = 64'd0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = 64'd0;
    mem_wdata = 64'd0; mem_wmask = 8'd0; bus_ack = 1'b0; bus_rdata = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    cycle();
    rst = 1'b0;

    // Fetch with ack three cycles after bus_req rises.
    set_in(1'b1, 64'h8000_0000, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 64'd0);
    chk("t1_if_gnt", 64'(if_gnt), 64'd1);
    cycle();
    chk("t1_bus_addr", bus_addr, 64'h8000_0000);
    set_in(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 64'd0);
    cycle();
    cycle();
    set_in(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b1, 64'h13);
    cycle();
    chk("t1_if_rvalid", 64'(if_rvalid), 64'd1);
    chk("t1_if_rdata", if_rdata, 64'h13);
    chk("t1_bus_req_off", 64'(bus_req), 64'd0);
    set_in(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 64'd0);
    cycle();

    // Simultaneous fetch and load: MEM wins, fetch follows once the bus is free.
    set_in(1'b1, 64'h8000_0004, 1'b1, 1'b0, 64'h8000_0100, 64'd0, 8'd0, 1'b0, 64'd0);
    chk("t2_mem_gnt", 64'(mem_gnt), 64'd1);
    chk("t2_if_wait", 64'(if_gnt), 64'd0);
    cycle();
    set_in(1'b1, 64'h8000_0004, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b1, 64'hAB);
    chk("t2_if_busy", 64'(if_gnt), 64'd0);
    cycle();
    chk("t2_mem_rdata", mem_rdata, 64'hAB);
    set_in(1'b1, 64'h8000_0004, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 64'd0);
    chk("t2_if_gnt", 64'(if_gnt), 64'd1);
    cycle();
    set_in(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b1, 64'h77);
    cycle();
    chk("t2_if_rdata", if_rdata, 64'h77);

    // Both requests held, ack every cycle: four MEM grants, then one IF grant.
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    set_in(1'b1, 64'h8000_0008, 1'b1, 1'b0, 64'h8000_0200, 64'd0, 8'd0, 1'b1, 64'h5A);
    for (int i = 0; i < 20; i++) begin
      if (if_gnt || mem_gnt) seq_if.push_back(if_gnt);
      cycle();
    end
    chk("t3_grant_count", 64'(seq_if.size()), 64'd10);
    for (int k = 0; k < seq_if.size(); k++) begin
      chk($sformatf("t3_grant_%0d_is_if", k), 64'(seq_if[k]), 64'((k % 5) == 4));
    end

    // Store: fields stay latched while the requester changes them.
    set_in(1'b0, 64'd0, 1'b1, 1'b1, 64'h8000_0300, 64'hDEAD_BEEF, 8'h0F, 1'b0, 64'd0);
    cycle();
    for (int i = 0; i < 2; i++) begin
      set_in(1'b0, 64'd0, 1'b0, 1'b0, 64'h1111, 64'h2222, 8'hF0, 1'b0, 64'd0);
      chk("t4_bus_we", 64'(bus_we), 64'd1);
      chk("t4_bus_wdata", bus_wdata, 64'hDEAD_BEEF);
      chk("t4_bus_wmask", 64'(bus_wmask), 64'h0F);
      cycle();
    end
    set_in(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b1, 64'h1234);
    cycle();
    chk("t4_mem_rvalid", 64'(mem_rvalid), 64'd1);
    chk("t4_mem_rdata", mem_rdata, 64'd0);

    // Reset while a load is in flight; the late ack is ignored.
    set_in(1'b0, 64'd0, 1'b1, 1'b0, 64'h8000_0400, 64'd0, 8'd0, 1'b0, 64'd0);
    cycle();
    set_in(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 64'd0);
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t5_bus_req", 64'(bus_req), 64'd0);
    set_in(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b1, 64'h55);
    cycle();
    chk("t5_no_rvalid", 64'(mem_rvalid), 64'd0);

    // Ack in IDLE with no requests changes nothing.
    set_in(1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b1, 64'h99);
    cycle();
    chk("t6_if_rvalid", 64'(if_rvalid), 64'd0);
    chk("t6_bus_req", 64'(bus_req), 64'd0);
    set_in(1'b1, 64'h8000_0500, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0, 1'b0, 64'd0);
    chk("t6_still_idle", 64'(if_gnt), 64'd1);
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if (!(if_req && !g_if)) begin
        if_req  = ($urandom_range(2) == 0);
        if_addr = {$urandom, $urandom};
      end
      if (!(mem_req && !g_mem)) begin
        mem_req   = ($urandom_range(1) == 0);
        mem_we    = $urandom_range(1) == 1;
        mem_addr  = {$urandom, $urandom};
        mem_wdata = {$urandom, $urandom};
        mem_wmask = 8'($urandom);
      end
      rst       = ($urandom_range(149) == 0);
      bus_ack   = ($urandom_range(2) == 0);
      bus_rdata = {$urandom, $urandom};
      #1;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
